nrisc_mc: RTL and testbench

Parametrised multicycle successor to the 8-bit single-cycle nRisc core. It executes the same 8-bit instruction format, but sequences each instruction through a fetch/decode/execute/memory/writeback state machine. Instruction and data memory share one valid/ready port, so wait states are tolerated. Data width and address width are generic, and the block sits between the top-level memory subsystem and the debug/trace logic.

---
 rtl/nrisc_pkg.sv | 35 +++
 rtl/nrisc_regfile.sv | 37 +++
 rtl/nrisc_mc.sv | 237 +++++++++++++++++++++++
 tb/tb_nrisc_mc.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared types and constants for the nrisc_mc multicycle core.
// Holds the opcode and FSM state enums, the instruction field positions
// and the index of r7, the implicit SLT destination and branch comparand.
package nrisc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADDI = 3'd2,
        OP_SLT  = 3'd3,
        OP_LW   = 3'd4,
        OP_SW   = 3'd5,
        OP_BEQ  = 3'd6,
        OP_BNE  = 3'd7
    } opcodeT;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } stateT;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RA_MSB  = 4;
    localparam int RA_LSB  = 2;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;

    localparam int          REG_COUNT = 8;
    localparam logic [2:0]  R7_IDX    = 3'd7;

endpackage

// File: rtl/nrisc_regfile.sv
// nrisc_regfile: eight-entry register file with three combinational read
// ports (rA, rB, r7) and one clocked write port. r0 is an ordinary register.
module nrisc_regfile
    import nrisc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        raAddr_i,
    input  logic [2:0]        rbAddr_i,
    output logic [DATA_W-1:0] raData_o,
    output logic [DATA_W-1:0] rbData_o,
    output logic [DATA_W-1:0] r7Data_o,
    input  logic              we_i,
    input  logic [2:0]        wAddr_i,
    input  logic [DATA_W-1:0] wData_i
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // Storage: cleared by the asynchronous reset, written once per WB cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[wAddr_i] <= wData_i;
        end
    end

    assign raData_o = regs_q[raAddr_i];
    assign rbData_o = regs_q[rbAddr_i];
    assign r7Data_o = regs_q[R7_IDX];

endmodule

// File: rtl/nrisc_mc.sv
// nrisc_mc: multicycle 8-bit-ISA nRisc core with a shared valid/ready
// memory port. Each instruction walks FETCH/DECODE/EXEC/(MEM)/(WB).
// Optional feature macro: NRISC_INSTRET_EN adds the 32-bit instret counter.
module nrisc_mc
    import nrisc_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic              retire
`ifdef NRISC_INSTRET_EN
    ,
    output logic [31:0]       instret
`endif
);

    stateT             state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        ir_q, ir_d;
    logic [DATA_W-1:0] opA_q, opA_d;
    logic [DATA_W-1:0] opB_q, opB_d;
    logic [DATA_W-1:0] opR7_q, opR7_d;
    logic [DATA_W-1:0] result_q, result_d;

    opcodeT            opcode;
    logic [2:0]        raIdx;
    logic [2:0]        rbIdx;
    logic [DATA_W-1:0] raData, rbData, r7Data;
    logic [DATA_W-1:0] immExt;
    logic [DATA_W-1:0] aluOut;
    logic              isBranch;
    logic              branchTaken;
    logic              rfWe;
    logic [2:0]        rfWAddr;

    assign opcode   = opcodeT'(ir_q[OPC_MSB:OPC_LSB]);
    assign raIdx    = ir_q[RA_MSB:RA_LSB];
    assign rbIdx    = {1'b0, ir_q[RB_MSB:RB_LSB]};
    assign immExt   = {{(DATA_W-2){ir_q[RB_MSB]}}, ir_q[RB_MSB:RB_LSB]};
    assign isBranch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign rfWe     = (state_q == ST_WB);
    assign rfWAddr  = (opcode == OP_SLT) ? R7_IDX : raIdx;
    assign pc_o     = pc_q;

    nrisc_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .raAddr_i (raIdx),
        .rbAddr_i (rbIdx),
        .raData_o (raData),
        .rbData_o (rbData),
        .r7Data_o (r7Data),
        .we_i     (rfWe),
        .wAddr_i  (rfWAddr),
        .wData_i  (result_q)
    );

    // ALU works on the operand latches so its inputs are stable through EXEC
    always_comb begin
        aluOut = '0;
        case (opcode)
            OP_ADD:  aluOut = opA_q + opB_q;
            OP_SUB:  aluOut = opA_q - opB_q;
            OP_ADDI: aluOut = opA_q + immExt;
            OP_SLT:  aluOut = {{(DATA_W-1){1'b0}}, ($signed(opA_q) < $signed(opB_q))};
            default: aluOut = '0;
        endcase
    end

    // Branch condition compares rA against r7, as latched in DECODE
    always_comb begin
        branchTaken = 1'b0;
        if (opcode == OP_BEQ) begin
            branchTaken = (opA_q == opR7_q);
        end else if (opcode == OP_BNE) begin
            branchTaken = (opA_q != opR7_q);
        end
    end

    // FSM state register; reset returns to FETCH at RESET_PC
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: memory states wait for mem_ready, others advance
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (isBranch) begin
                    state_d = ST_FETCH;
                end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (opcode == OP_SW) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_FETCH;
        endcase
    end

    // FSM outputs: bus request only in FETCH/MEM, all forced low during reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        retire    = 1'b0;
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                ST_EXEC: begin
                    retire = isBranch;
                end
                ST_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = addr_q;
                    if (opcode == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = opA_q;
                        retire    = mem_ready;
                    end
                end
                ST_WB: begin
                    retire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath next values: IR/PC on fetch, operands in DECODE, results later
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        addr_d   = addr_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        opR7_d   = opR7_q;
        result_d = result_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d = mem_rdata[7:0];
                    pc_d = pc_q + 1'b1;
                end
            end
            ST_DECODE: begin
                opA_d  = raData;
                opB_d  = rbData;
                opR7_d = r7Data;
            end
            ST_EXEC: begin
                result_d = aluOut;
                addr_d   = ADDR_W'(opB_q);
                if (branchTaken) begin
                    pc_d = ADDR_W'(opB_q);
                end
            end
            ST_MEM: begin
                if (mem_ready && (opcode == OP_LW)) begin
                    result_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers with asynchronous reset to their architectural values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            addr_q   <= '0;
            opA_q    <= '0;
            opB_q    <= '0;
            opR7_q   <= '0;
            result_q <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            addr_q   <= addr_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            opR7_q   <= opR7_d;
            result_q <= result_d;
        end
    end

`ifdef NRISC_INSTRET_EN
    logic [31:0] instret_q;

    // Retired-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_nrisc_mc.sv
// tb_nrisc_mc: directed bench for nrisc_mc with a shared-memory model.
// Program space lives at 0x10 and above, data below 0x10 so the model can
// give data accesses their own wait-state count.
module tb_nrisc_mc;

    logic       clock;
    logic       reset;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       mem_ready;
    logic [7:0] pc_o;
    logic       retire;
`ifdef NRISC_INSTRET_EN
    logic [31:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] memArr [256];
    logic [7:0] ovlData [256];
    bit         ovlValid [256];
    int         waitCnt;
    int         needWait;
    int         fetchWait = 0;
    int         dataWait  = 0;
    bit         tieReady  = 1'b1;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] storeInstr;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expected;
    } vecT;

    vecT vecs [11];

    nrisc_mc #(
        .DATA_W   (8),
        .ADDR_W   (8),
        .RESET_PC (8'h10)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc_o      (pc_o),
        .retire    (retire)
`ifdef NRISC_INSTRET_EN
        ,
        .instret   (instret)
`endif
    );

    // Free-running clock, 10 time units per period
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory responder: ready after the configured number of wait cycles
    assign needWait  = (mem_addr < 8'h10) ? dataWait : fetchWait;
    assign mem_ready = tieReady ? 1'b1 : (mem_req && (waitCnt >= needWait));
    assign mem_rdata = ovlValid[mem_addr] ? ovlData[mem_addr] : memArr[mem_addr];

    // Wait counter and store overlay, both cleared while the DUT is in reset
    always @(posedge clock) begin
        if (!reset) begin
            waitCnt <= 0;
            for (int i = 0; i < 256; i++) begin
                ovlValid[i] <= 1'b0;
            end
        end else if (mem_req && mem_ready) begin
            waitCnt <= 0;
            if (mem_we) begin
                ovlValid[mem_addr] <= 1'b1;
                ovlData[mem_addr]  <= mem_wdata;
            end
        end else if (mem_req) begin
            waitCnt <= waitCnt + 1;
        end
    end

    // Global watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", what, actual, expected);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) begin
            memArr[i] = 8'h00;
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic waitRetire(input int maxCycles, output int n, output logic [7:0] firstAddr);
        n = 0;
        firstAddr = 8'hxx;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) firstAddr = mem_addr;
        end while (!retire && n < maxCycles);
        if (!retire) n = -1;
    endtask

    task automatic waitStore(input int maxCycles, output logic seen);
        seen = 1'b0;
        for (int c = 0; c < maxCycles && !seen; c++) begin
            @(negedge clock);
            if (mem_req && mem_we) seen = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vecT v, input int idx);
        logic seen;
        clearMem();
        memArr[8'h00] = v.a;
        memArr[8'h01] = v.b;
        memArr[8'h10] = 8'h45;
        memArr[8'h11] = 8'h88;
        memArr[8'h12] = 8'h8D;
        memArr[8'h13] = v.instr;
        memArr[8'h14] = v.storeInstr;
        tieReady = 1'b1;
        doReset();
        waitStore(60, seen);
        checkOutput($sformatf("vec%0d.storeSeen", idx), {31'd0, seen}, 32'd1);
        checkOutput($sformatf("vec%0d.storeAddr", idx), {24'd0, mem_addr}, 32'h01);
        checkOutput($sformatf("vec%0d.storeData", idx), {24'd0, mem_wdata}, {24'd0, v.expected});
    endtask

    initial begin
        int n;
        int good;
        int retAt;
        logic [7:0] fa;
        logic seen;

        vecs[0]  = '{8'h0B, 8'hA9, 8'h05, 8'h03, 8'h08};
        vecs[1]  = '{8'h0B, 8'hA9, 8'hFF, 8'h02, 8'h01};
        vecs[2]  = '{8'h2B, 8'hA9, 8'h05, 8'h07, 8'hFE};
        vecs[3]  = '{8'h2B, 8'hA9, 8'h80, 8'h01, 8'h7F};
        vecs[4]  = '{8'h4B, 8'hA9, 8'h00, 8'h33, 8'hFF};
        vecs[5]  = '{8'h4A, 8'hA9, 8'h05, 8'h33, 8'h03};
        vecs[6]  = '{8'h6B, 8'hBD, 8'h80, 8'h01, 8'h01};
        vecs[7]  = '{8'h6B, 8'hBD, 8'h01, 8'h80, 8'h00};
        vecs[8]  = '{8'h6B, 8'hBD, 8'h05, 8'h05, 8'h00};
        vecs[9]  = '{8'h6B, 8'hBD, 8'hFE, 8'hFF, 8'h01};
        vecs[10] = '{8'h7F, 8'hBD, 8'h7F, 8'h80, 8'h00};
        vecs[10].instr = 8'h6B;

        reset = 1'b0;

        // Reset behaviour with mem_ready tied high
        clearMem();
        memArr[8'h10] = 8'h45;
        tieReady = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("inReset.mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("inReset.mem_addr", {24'd0, mem_addr}, 32'd0);
        checkOutput("inReset.pc_o", {24'd0, pc_o}, 32'h10);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("afterReset.mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("afterReset.mem_addr", {24'd0, mem_addr}, 32'h10);
        checkOutput("afterReset.mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("afterReset.mem_wdata", {24'd0, mem_wdata}, 32'd0);
        checkOutput("afterReset.retire", {31'd0, retire}, 32'd0);
        checkOutput("afterReset.pc_o", {24'd0, pc_o}, 32'h10);
`ifdef NRISC_INSTRET_EN
        checkOutput("afterReset.instret", instret, 32'd0);
`endif
        @(negedge clock);
        checkOutput("firstFetch.pc_o", {24'd0, pc_o}, 32'h11);

        // Table-driven ALU / SLT vectors
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        // ADDI r1,1 x3 then ADD r1,r1; retire at cycles 4, 8, 12, 16
        clearMem();
        memArr[8'h10] = 8'h45;
        memArr[8'h11] = 8'h45;
        memArr[8'h12] = 8'h45;
        memArr[8'h13] = 8'h05;
        memArr[8'h14] = 8'hA4;
        tieReady = 1'b1;
        doReset();
        for (int k = 0; k < 4; k++) begin
            waitRetire(20, n, fa);
            checkOutput($sformatf("seqB.cycles%0d", k), n, 32'd4);
            checkOutput($sformatf("seqB.fetch%0d", k), {24'd0, fa}, 32'h10 + k);
        end
`ifdef NRISC_INSTRET_EN
        @(negedge clock);
        checkOutput("seqB.instret", instret, 32'd4);
`endif
        waitStore(20, seen);
        checkOutput("seqB.storeSeen", {31'd0, seen}, 32'd1);
        checkOutput("seqB.r1", {24'd0, mem_wdata}, 32'h06);
        checkOutput("seqB.storeAddr", {24'd0, mem_addr}, 32'h00);

        // SW r5->[r1], LW r6<-[r1] with three data wait states per access
        clearMem();
        memArr[8'h00] = 8'h5A;
        memArr[8'h10] = 8'h94;
        memArr[8'h11] = 8'h45;
        memArr[8'h12] = 8'hB5;
        memArr[8'h13] = 8'h99;
        memArr[8'h14] = 8'hB8;
        tieReady  = 1'b0;
        fetchWait = 0;
        dataWait  = 3;
        doReset();
        waitRetire(30, n, fa);
        checkOutput("seqC.lwR5Cycles", n, 32'd8);
        waitRetire(30, n, fa);
        checkOutput("seqC.addiCycles", n, 32'd4);
        good  = 0;
        retAt = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (c >= 4 && mem_req && mem_we && mem_addr == 8'h01 && mem_wdata == 8'h5A) good++;
            if (retire && retAt == 0) retAt = c;
        end
        checkOutput("seqC.swHeldCycles", good, 32'd4);
        checkOutput("seqC.swRetireCycle", retAt, 32'd7);
        waitRetire(30, n, fa);
        checkOutput("seqC.lwR6Cycles", n, 32'd8);
        waitStore(30, seen);
        checkOutput("seqC.storeSeen", {31'd0, seen}, 32'd1);
        checkOutput("seqC.r6", {24'd0, mem_wdata}, 32'h5A);

        // Branches: BEQ taken to 0x20, BNE not taken, wrap from 0xFF to 0x00
        clearMem();
        memArr[8'h00] = 8'h20;
        memArr[8'h10] = 8'h8C;
        memArr[8'h11] = 8'hC3;
        memArr[8'h20] = 8'hE3;
        memArr[8'h21] = 8'h4B;
        memArr[8'h22] = 8'hC2;
        memArr[8'hFF] = 8'h45;
        tieReady = 1'b1;
        doReset();
        waitRetire(20, n, fa);
        checkOutput("seqD.lwCycles", n, 32'd5);
        waitRetire(20, n, fa);
        checkOutput("seqD.beqCycles", n, 32'd3);
        waitRetire(20, n, fa);
        checkOutput("seqD.beqTarget", {24'd0, fa}, 32'h20);
        checkOutput("seqD.bneCycles", n, 32'd3);
        waitRetire(20, n, fa);
        checkOutput("seqD.bneFallThrough", {24'd0, fa}, 32'h21);
        waitRetire(20, n, fa);
        checkOutput("seqD.beqFFAddr", {24'd0, fa}, 32'h22);
        waitRetire(20, n, fa);
        checkOutput("seqD.fetchFF", {24'd0, fa}, 32'hFF);
        checkOutput("seqD.pcWrapped", {24'd0, pc_o}, 32'h00);
        waitRetire(20, n, fa);
        checkOutput("seqD.fetchWrap", {24'd0, fa}, 32'h00);

        // Reset asserted in the middle of a stalled MEM access
        clearMem();
        memArr[8'h10] = 8'h45;
        memArr[8'h11] = 8'h88;
        tieReady  = 1'b0;
        fetchWait = 0;
        dataWait  = 20;
        doReset();
        waitRetire(20, n, fa);
        checkOutput("seqE.addiCycles", n, 32'd4);
        repeat (5) @(negedge clock);
        checkOutput("seqE.stallReq", {31'd0, mem_req}, 32'd1);
        checkOutput("seqE.stallPc", {24'd0, pc_o}, 32'h12);
`ifdef NRISC_INSTRET_EN
        checkOutput("seqE.instretBefore", instret, 32'd1);
`endif
        reset = 1'b0;
        #1;
        checkOutput("seqE.reqDropped", {31'd0, mem_req}, 32'd0);
        checkOutput("seqE.pcReset", {24'd0, pc_o}, 32'h10);
`ifdef NRISC_INSTRET_EN
        checkOutput("seqE.instretReset", instret, 32'd0);
`endif
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checkOutput("seqE.refetchReq", {31'd0, mem_req}, 32'd1);
        checkOutput("seqE.refetchAddr", {24'd0, mem_addr}, 32'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
